// File: rtl/sq_square.sv
// Iterative shift-and-add squarer: a small controller FSM sequences a datapath
// that accumulates num * num one multiplier bit at a time.
module sq_square #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   num,
  input  logic               ready,
  output logic [2*WIDTH-1:0] sq,
  output logic               done,
  output logic               busy,
  output logic [2:0]         cs
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] sq_q, sq_d;

  logic load, add_en, shift_en, sq_en;

  // Controller
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    sq_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (ready) begin
          load    = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // An exhausted multiplier ends the loop early, skipping high-order zeros.
        if (mplier_q == '0) begin
          sq_en   = 1'b1;
          state_d = StDone;
        end else if (mplier_q[0]) begin
          state_d = StAdd;
        end else begin
          state_d = StShift;
        end
      end
      StAdd: begin
        add_en  = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        shift_en = 1'b1;
        state_d  = StCheck;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sq_d     = sq_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, num};
      mplier_d = num;
      acc_d    = '0;
    end
    if (add_en) begin
      acc_d = acc_q + mcand_q;
    end
    if (shift_en) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    if (sq_en) begin
      sq_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sq_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sq_q     <= sq_d;
    end
  end

  assign sq   = sq_q;
  assign cs   = state_q;
  assign done = (state_q == StDone);
  assign busy = (state_q != StIdle);

endmodule
